kronos_mem_arbiter: RTL and testbench
=====================================

# kronos_mem_arbiter

Shares one single-port memory between the Kronos core's instruction-fetch and load/store channels. Each channel uses the core's native req/ack handshake; the arbiter drives a req/gnt memory port with one-cycle read latency and returns a single-cycle ack with read data. It sits between `kronos_core` and a unified instruction/data SRAM, replacing the dual-port wiring.

## Interface
- `AddrWidth`, default 20: memory word-address width; the low `AddrWidth` bits of the 32-bit core address are forwarded.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  asynchronous reset, active-high.
- `instr_req`  in  1  fetch request; held with `instr_addr` stable until `instr_ack`.
- `instr_addr`  in  32  fetch address.
- `instr_ack`  out  1  one-cycle fetch completion.
- `instr_data`  out  32  fetch data, valid with `instr_ack`.
- `data_req`  in  1  load/store request; held with all data inputs stable until `data_ack`.
- `data_addr`  in  32  load/store address.
- `data_wr_data`  in  32  store data.
- `data_mask`  in  4  byte enables.
- `data_wr_en`  in  1  1 = store, 0 = load.
- `data_ack`  out  1  one-cycle load/store completion.
- `data_rd_data`  out  32  load data, valid with `data_ack`.
- `mem_req`  out  1  memory request.
- `mem_gnt`  in  1  memory accepts the beat when `mem_req & mem_gnt`.
- `mem_addr`  out  AddrWidth  memory address.
- `mem_wdata`  out  32  write data.
- `mem_strb`  out  32  bit strobe; bit i = `data_mask[i/8]`.
- `mem_we`  out  1  write enable.
- `mem_rdata`  in  32  read data, valid the cycle after an accepted beat.

## Operation
- FSM states: IDLE, REQ, RESP. The FSM has a single transaction in flight.
- IDLE: if any req is high, latch `owner` and go to REQ. Otherwise stay in IDLE.
- If only one req is high, that requester wins. If both are high, the tie rule under Configuration applies.
- REQ: `mem_req`=1, with address, data, strobe and we muxed from `owner`.
  - An instruction owner drives `mem_we`=0, `mem_wdata`=0 and `mem_strb`=0.
  - On `mem_gnt`=1, go to RESP. Otherwise hold REQ with all outputs stable.
- RESP: pulse the owner's ack for one cycle and pass `mem_rdata` combinationally to the owner's data output. Stores are acked the same way as loads. Next state is always IDLE.
- All `mem_*` outputs are 0 outside REQ. Acks are 0 outside RESP. `instr_data` and `data_rd_data` are 0 when their ack is low.
- A requester's req seen in the same cycle as its own ack is not arbitrated. Arbitration only happens in IDLE.
- A req that drops while in REQ is a protocol violation; the transaction completes anyway.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `owner`=INSTR, `last_owner`=INSTR. All outputs go to 0 immediately, including mid-transaction. An in-flight beat is abandoned and its ack is never issued.
- Minimum transaction, with req at cycle 0 and `mem_gnt` tied to 1:
  - cycle 1: `mem_req`=1.
  - cycle 2: ack=1.
  - cycle 3: IDLE, arbitration possible again.
- Back-to-back issue from IDLE is every 3 cycles. Each cycle of `mem_gnt` stall in REQ adds one cycle.
- Both reqs high in IDLE: the loser is served next, with its `mem_req` 3 cycles after the winner's.
- Requests and ack never combinationally depend on each other; `mem_req` depends only on state.

## Configuration
- `KRONOS_MEM_ARB_RR_EN` defined: round-robin on ties.
  - The winner is the requester that is not `last_owner`.
  - `last_owner` updates on every IDLE→REQ transition.
  - The reset value INSTR means the first tie goes to data.
- `KRONOS_MEM_ARB_RR_EN` undefined: fixed priority; data always wins ties. The `last_owner` register is not implemented.

## Test plan
- Single fetch: `instr_req`=1, `instr_addr`=0x8000_0010, `mem_gnt`=1, `mem_rdata`=0x0000_0013 → `mem_req` at cycle 1 with `mem_addr`=0x00010 and `mem_we`=0; `instr_ack`=1 with `instr_data`=0x0000_0013 at cycle 2.
- Store strobe expansion: `data_req`=1, `data_wr_en`=1, `data_mask`=0b0101, `data_wr_data`=0xDEAD_BEEF → `mem_strb`=0x00FF_00FF, `mem_wdata`=0xDEAD_BEEF, `mem_we`=1; `data_ack` pulses once.
- Grant stall: `mem_gnt`=0 for 4 cycles in REQ → `mem_req` and `mem_addr` held stable for 5 cycles; ack appears exactly 1 cycle after the gnt cycle.
- Contention: both reqs held continuously for 6 transactions.
  - With RR: grants alternate D,I,D,I,D,I.
  - Without RR: data starves instr until `data_req` drops. The bench holds `data_req` for 3 transactions, after which instr is granted next.
- Reset mid-transaction: assert `rst_i` while in REQ → `mem_req`=0 immediately with no ack. After release, a new fetch completes normally within 3 cycles.
- Idle quiescence: no reqs for 10 cycles → all outputs remain 0; `mem_rdata` toggling never reaches `instr_data` or `data_rd_data`.

Source files
------------

// File: rtl/kronos_mem_arbiter_if.sv
// Bundle of Kronos fetch/LSU req-ack channels and the shared req-gnt memory port.
// slave is the arbiter's view; master is the core-plus-SRAM view driving it.
interface kronos_mem_arbiter_if #(
   parameter int AddrWidth = 20
);
   logic                 instr_req;
   logic [31:0]          instr_addr;
   logic                 instr_ack;
   logic [31:0]          instr_data;

   logic                 data_req;
   logic [31:0]          data_addr;
   logic [31:0]          data_wr_data;
   logic [3:0]           data_mask;
   logic                 data_wr_en;
   logic                 data_ack;
   logic [31:0]          data_rd_data;

   logic                 mem_req;
   logic                 mem_gnt;
   logic [AddrWidth-1:0] mem_addr;
   logic [31:0]          mem_wdata;
   logic [31:0]          mem_strb;
   logic                 mem_we;
   logic [31:0]          mem_rdata;

   modport slave (
      input  instr_req, instr_addr,
      output instr_ack, instr_data,
      input  data_req, data_addr, data_wr_data, data_mask, data_wr_en,
      output data_ack, data_rd_data,
      output mem_req, mem_addr, mem_wdata, mem_strb, mem_we,
      input  mem_gnt, mem_rdata
   );

   modport master (
      output instr_req, instr_addr,
      input  instr_ack, instr_data,
      output data_req, data_addr, data_wr_data, data_mask, data_wr_en,
      input  data_ack, data_rd_data,
      input  mem_req, mem_addr, mem_wdata, mem_strb, mem_we,
      output mem_gnt, mem_rdata
   );
endinterface

// File: rtl/kronos_mem_arbiter.sv
// Fetch/LSU arbiter onto one SRAM port: mem_req 1 cycle after req, ack 2 cycles (+1 per mem_gnt stall), one beat in flight.
// Ties go to data, or alternate when KRONOS_MEM_ARB_RR_EN is defined; core reqs simply wait in IDLE while busy.
module kronos_mem_arbiter #(
   parameter int AddrWidth = 20
) (
   input  logic                clk_i,
   input  logic                rst_i,
   kronos_mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic {
      OWN_INSTR = 1'b0,
      OWN_DATA  = 1'b1
   } owner_t;

   state_t state_q, state_d;
   owner_t owner_q, winner, tie_winner;
   logic   any_req, launch;

   assign any_req = bus.instr_req | bus.data_req;
   assign launch  = (state_q == IDLE) && any_req;

`ifdef KRONOS_MEM_ARB_RR_EN
   owner_t last_owner_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         last_owner_q <= OWN_INSTR;
      end else if (launch) begin
         last_owner_q <= winner;
      end
   end

   assign tie_winner = (last_owner_q == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
`else
   assign tie_winner = OWN_DATA;
`endif

   always_comb begin
      winner = OWN_INSTR;
      if (bus.instr_req && bus.data_req) begin
         winner = tie_winner;
      end else if (bus.data_req) begin
         winner = OWN_DATA;
      end
   end

   // owner is frozen for the whole REQ/RESP pair so the mux cannot glitch on a late req change
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         owner_q <= OWN_INSTR;
      end else if (launch) begin
         owner_q <= winner;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req) state_d = REQ;
         REQ:     if (bus.mem_gnt) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req      = 1'b0;
      bus.mem_addr     = '0;
      bus.mem_wdata    = '0;
      bus.mem_strb     = '0;
      bus.mem_we       = 1'b0;
      bus.instr_ack    = 1'b0;
      bus.instr_data   = '0;
      bus.data_ack     = 1'b0;
      bus.data_rd_data = '0;
      case (state_q)
         REQ: begin
            bus.mem_req = 1'b1;
            if (owner_q == OWN_DATA) begin
               bus.mem_addr  = bus.data_addr[AddrWidth-1:0];
               bus.mem_wdata = bus.data_wr_data;
               bus.mem_we    = bus.data_wr_en;
               for (int b = 0; b < 4; b++) begin
                  bus.mem_strb[8*b +: 8] = {8{bus.data_mask[b]}};
               end
            end else begin
               bus.mem_addr = bus.instr_addr[AddrWidth-1:0];
            end
         end
         RESP: begin
            if (owner_q == OWN_DATA) begin
               bus.data_ack     = 1'b1;
               bus.data_rd_data = bus.mem_rdata;
            end else begin
               bus.instr_ack  = 1'b1;
               bus.instr_data = bus.mem_rdata;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Self-checking bench for kronos_mem_arbiter; follows KRONOS_MEM_ARB_RR_EN to pick the tie-break model.
module tb_kronos_mem_arbiter;

   localparam int AW = 20;
`ifdef KRONOS_MEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_i;
   int   chk_cnt = 0;
   int   pass_cnt = 0;

   always #5 clk_i = ~clk_i;

   kronos_mem_arbiter_if #(.AddrWidth(AW)) bus ();

   kronos_mem_arbiter #(.AddrWidth(AW)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sample();
      @(negedge clk_i);
   endtask

   task automatic clear_inputs();
      bus.instr_req    = 1'b0;
      bus.instr_addr   = '0;
      bus.data_req     = 1'b0;
      bus.data_addr    = '0;
      bus.data_wr_data = '0;
      bus.data_mask    = '0;
      bus.data_wr_en   = 1'b0;
      bus.mem_gnt      = 1'b0;
      bus.mem_rdata    = '0;
   endtask

   task automatic apply_reset();
      rst_i = 1'b1;
      clear_inputs();
      step();
      step();
      rst_i = 1'b0;
   endtask

   function automatic logic [31:0] strb_of(input logic [3:0] m);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r[i] = m[i/8];
      return r;
   endfunction

   task automatic test_reset();
      rst_i = 1'b1;
      clear_inputs();
      bus.mem_rdata = 32'hFFFF_FFFF;
      sample();
      chk_cnt++;
      if (bus.mem_req !== 1'b0) $display("FAIL reset_mem_req: got %b expected 0", bus.mem_req);
      else pass_cnt++;
      chk_cnt++;
      if (bus.mem_addr !== '0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr);
      else pass_cnt++;
      chk_cnt++;
      if ({bus.instr_ack, bus.data_ack} !== 2'b00)
         $display("FAIL reset_acks: got %b expected 00", {bus.instr_ack, bus.data_ack});
      else pass_cnt++;
      chk_cnt++;
      if (bus.instr_data !== '0) $display("FAIL reset_instr_data: got %h expected 0", bus.instr_data);
      else pass_cnt++;
      step();
      rst_i = 1'b0;
      bus.mem_rdata = '0;
   endtask

   task automatic test_single_fetch();
      bus.instr_req  = 1'b1;
      bus.instr_addr = 32'h8000_0010;
      bus.mem_gnt    = 1'b1;
      bus.mem_rdata  = 32'h0000_0013;
      sample();
      chk_cnt++;
      if (bus.mem_req !== 1'b0) $display("FAIL fetch_c0_mem_req: got %b expected 0", bus.mem_req);
      else pass_cnt++;
      step();
      sample();
      chk_cnt++;
      if ({bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_strb, bus.mem_wdata} !== {1'b1, 20'h00010, 1'b0, 64'h0})
         $display("FAIL fetch_c1_beat: got req=%b addr=%h we=%b strb=%h wdata=%h expected req=1 addr=00010 we=0 strb=0 wdata=0",
                  bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_strb, bus.mem_wdata);
      else pass_cnt++;
      step();
      sample();
      chk_cnt++;
      if ({bus.instr_ack, bus.instr_data, bus.data_ack, bus.mem_req} !== {1'b1, 32'h0000_0013, 1'b0, 1'b0})
         $display("FAIL fetch_c2_ack: got ack=%b data=%h dack=%b mreq=%b expected ack=1 data=00000013 dack=0 mreq=0",
                  bus.instr_ack, bus.instr_data, bus.data_ack, bus.mem_req);
      else pass_cnt++;
      step();
      bus.instr_req = 1'b0;
      sample();
      chk_cnt++;
      if (bus.instr_ack !== 1'b0) $display("FAIL fetch_c3_ack_single: got %b expected 0", bus.instr_ack);
      else pass_cnt++;
      step();
   endtask

   task automatic test_store();
      int acks = 0;
      bus.data_req     = 1'b1;
      bus.data_wr_en   = 1'b1;
      bus.data_mask    = 4'b0101;
      bus.data_wr_data = 32'hDEAD_BEEF;
      bus.data_addr    = 32'h0000_1234;
      bus.mem_gnt      = 1'b1;
      step();
      sample();
      chk_cnt++;
      if ({bus.mem_strb, bus.mem_wdata, bus.mem_we, bus.mem_addr} !== {32'h00FF_00FF, 32'hDEAD_BEEF, 1'b1, 20'h01234})
         $display("FAIL store_beat: got strb=%h wdata=%h we=%b addr=%h expected strb=00ff00ff wdata=deadbeef we=1 addr=01234",
                  bus.mem_strb, bus.mem_wdata, bus.mem_we, bus.mem_addr);
      else pass_cnt++;
      step();
      for (int c = 2; c < 7; c++) begin
         if (c == 3) bus.data_req = 1'b0;
         sample();
         if (bus.data_ack === 1'b1) acks++;
         step();
      end
      chk_cnt++;
      if (acks !== 1) $display("FAIL store_ack_pulses: got %0d expected 1", acks);
      else pass_cnt++;
      clear_inputs();
   endtask

   task automatic test_grant_stall();
      bus.instr_req  = 1'b1;
      bus.instr_addr = 32'h0000_0ABC;
      bus.mem_gnt    = 1'b0;
      step();
      for (int s = 0; s < 5; s++) begin
         bus.mem_gnt = (s == 4);
         sample();
         chk_cnt++;
         if ({bus.mem_req, bus.mem_addr, bus.instr_ack} !== {1'b1, 20'h00ABC, 1'b0})
            $display("FAIL stall_hold_%0d: got req=%b addr=%h ack=%b expected req=1 addr=00abc ack=0",
                     s, bus.mem_req, bus.mem_addr, bus.instr_ack);
         else pass_cnt++;
         step();
      end
      bus.mem_rdata = 32'h1234_5678;
      sample();
      chk_cnt++;
      if ({bus.instr_ack, bus.instr_data} !== {1'b1, 32'h1234_5678})
         $display("FAIL stall_ack: got ack=%b data=%h expected ack=1 data=12345678", bus.instr_ack, bus.instr_data);
      else pass_cnt++;
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_contention();
      int  n_tx;
      bit  exp_d;
      apply_reset();
      n_tx = RR ? 6 : 4;
      bus.instr_req  = 1'b1;
      bus.instr_addr = 32'h0000_0111;
      bus.data_req   = 1'b1;
      bus.data_addr  = 32'h0000_0222;
      bus.mem_gnt    = 1'b1;
      for (int k = 0; k < n_tx; k++) begin
         exp_d = RR ? (k % 2 == 0) : (k < 3);
         step();
         sample();
         chk_cnt++;
         if ({bus.mem_req, bus.mem_addr} !== {1'b1, exp_d ? 20'h00222 : 20'h00111})
            $display("FAIL contention_grant_%0d: got req=%b addr=%h expected owner %s", k, bus.mem_req, bus.mem_addr,
                     exp_d ? "data" : "instr");
         else pass_cnt++;
         step();
         sample();
         chk_cnt++;
         if ({bus.data_ack, bus.instr_ack} !== {exp_d, ~exp_d})
            $display("FAIL contention_ack_%0d: got dack=%b iack=%b expected dack=%b iack=%b", k,
                     bus.data_ack, bus.instr_ack, exp_d, ~exp_d);
         else pass_cnt++;
         step();
         if (!RR && k == 2) bus.data_req = 1'b0;
      end
      clear_inputs();
      step();
   endtask

   task automatic test_reset_mid();
      bus.instr_req  = 1'b1;
      bus.instr_addr = 32'h0000_0040;
      bus.mem_gnt    = 1'b0;
      step();
      sample();
      chk_cnt++;
      if (bus.mem_req !== 1'b1) $display("FAIL rstmid_in_req: got %b expected 1", bus.mem_req);
      else pass_cnt++;
      #2;
      rst_i = 1'b1;
      bus.mem_gnt = 1'b1;
      #1;
      chk_cnt++;
      if ({bus.mem_req, bus.mem_addr, bus.instr_ack} !== {1'b1 ^ 1'b1, 20'h0, 1'b0})
         $display("FAIL rstmid_immediate: got req=%b addr=%h ack=%b expected all 0", bus.mem_req, bus.mem_addr, bus.instr_ack);
      else pass_cnt++;
      for (int c = 0; c < 2; c++) begin
         sample();
         chk_cnt++;
         if ({bus.mem_req, bus.instr_ack, bus.data_ack} !== 3'b000)
            $display("FAIL rstmid_hold_%0d: got req=%b iack=%b dack=%b expected 000", c, bus.mem_req, bus.instr_ack, bus.data_ack);
         else pass_cnt++;
      end
      step();
      rst_i = 1'b0;
      bus.mem_rdata = 32'h0000_0005;
      step();
      sample();
      chk_cnt++;
      if ({bus.mem_req, bus.mem_addr} !== {1'b1, 20'h00040})
         $display("FAIL rstmid_refetch_req: got req=%b addr=%h expected req=1 addr=00040", bus.mem_req, bus.mem_addr);
      else pass_cnt++;
      step();
      sample();
      chk_cnt++;
      if ({bus.instr_ack, bus.instr_data} !== {1'b1, 32'h0000_0005})
         $display("FAIL rstmid_refetch_ack: got ack=%b data=%h expected ack=1 data=00000005", bus.instr_ack, bus.instr_data);
      else pass_cnt++;
      step();
      clear_inputs();
      step();
   endtask

   task automatic test_idle_quiescence();
      logic [AW+32*4+4-1:0] obs;
      clear_inputs();
      for (int c = 0; c < 10; c++) begin
         bus.mem_rdata = $urandom;
         bus.mem_gnt   = 1'($urandom_range(0, 1));
         sample();
         obs = {bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_strb, bus.mem_we,
                bus.instr_ack, bus.instr_data, bus.data_ack, bus.data_rd_data};
         chk_cnt++;
         if (obs !== '0) $display("FAIL idle_quiet_%0d: got %h expected 0", c, obs);
         else pass_cnt++;
         step();
      end
      clear_inputs();
   endtask

   // Reference model: pending requests per channel, tie rule, and exact beat timing.
   task automatic test_random();
      bit          i_pend, d_pend, win_d, last_d;
      logic [31:0] i_addr, d_addr, d_wdata, rdata;
      logic [3:0]  d_mask;
      bit          d_we;
      int          stall;
      logic [87:0] obs, exp;
      logic [65:0] obs_r, exp_r;
      apply_reset();
      i_pend = 0; d_pend = 0; last_d = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; d_mask = '0; d_we = 0;
      for (int it = 0; it < 40; it++) begin
         if (!i_pend && $urandom_range(0, 1) == 1) begin
            i_pend = 1; i_addr = $urandom;
         end
         if (!d_pend && $urandom_range(0, 1) == 1) begin
            d_pend = 1; d_addr = $urandom; d_wdata = $urandom;
            d_mask = 4'($urandom_range(0, 15)); d_we = 1'($urandom_range(0, 1));
         end
         if (!i_pend && !d_pend) begin
            i_pend = 1; i_addr = $urandom;
         end
         bus.instr_req = i_pend; bus.instr_addr = i_addr;
         bus.data_req = d_pend; bus.data_addr = d_addr; bus.data_wr_data = d_wdata;
         bus.data_mask = d_mask; bus.data_wr_en = d_we;
         if (i_pend && d_pend) win_d = RR ? !last_d : 1'b1;
         else win_d = d_pend;
         last_d = win_d;
         exp = win_d ? {1'b1, d_we, d_addr[AW-1:0], d_wdata, strb_of(d_mask), 2'b00}
                     : {1'b1, 1'b0, i_addr[AW-1:0], 32'h0, 32'h0, 2'b00};
         step();
         stall = $urandom_range(0, 3);
         for (int s = 0; s <= stall; s++) begin
            bus.mem_gnt   = (s == stall);
            bus.mem_rdata = $urandom;
            sample();
            obs = {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_strb, bus.instr_ack, bus.data_ack};
            chk_cnt++;
            if (obs !== exp) $display("FAIL rand_beat_%0d_%0d: got %h expected %h", it, s, obs, exp);
            else pass_cnt++;
            step();
         end
         rdata = $urandom;
         bus.mem_rdata = rdata;
         bus.mem_gnt = 1'($urandom_range(0, 1));
         sample();
         obs_r = {bus.mem_req, bus.instr_ack, bus.data_ack, win_d ? bus.data_rd_data : bus.instr_data,
                  win_d ? bus.instr_data : bus.data_rd_data};
         exp_r = {1'b0, !win_d, win_d, rdata, 32'h0};
         chk_cnt++;
         if (obs_r !== exp_r) $display("FAIL rand_ack_%0d: got %h expected %h", it, obs_r, exp_r);
         else pass_cnt++;
         step();
         if (win_d) d_pend = 0;
         else i_pend = 0;
      end
      clear_inputs();
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_fetch();
      test_store();
      test_grant_stall();
      test_contention();
      test_reset_mid();
      test_idle_quiescence();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
